// File: rtl/shift_cmd_queue.sv
// First-word-fall-through command queue feeding a left-shift stage.
// Commands asking for a shift of 8 or more are handshaken, discarded and counted.
module shift_cmd_queue #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [7:0]               in_data,
    input  logic [3:0]               in_shift,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [7:0]               out_data,
    output logic [3:0]               out_shift,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     drop_pulse,
    output logic [7:0]               drop_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

    // Only shift amounts 0..7 are ever stored, so three bits per entry suffice.
    logic [7:0] data_mem  [DEPTH];
    logic [2:0] shift_mem [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          drop_pulse_q, drop_pulse_d;
    logic [7:0]    drop_count_q, drop_count_d;

    logic push_fire;
    logic push_store;
    logic push_reject;
    logic pop_fire;

    assign in_ready    = rst | (level_q != FULL_LEVEL);
    assign out_valid   = ~rst & (level_q != '0);
    assign push_fire   = in_valid & in_ready;
    assign push_store  = push_fire & ~in_shift[3];
    assign push_reject = push_fire & in_shift[3];
    assign pop_fire    = out_valid & out_ready;

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        level_d      = level_q;
        drop_pulse_d = push_reject;
        drop_count_d = drop_count_q;

        if (push_store) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_fire) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        case ({push_store, pop_fire})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase

        if (push_reject && (drop_count_q != 8'hFF)) begin
            drop_count_d = drop_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            drop_pulse_q <= 1'b0;
            drop_count_q <= 8'd0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            drop_pulse_q <= drop_pulse_d;
            drop_count_q <= drop_count_d;
        end
    end

    // Storage is left uncleared on reset; the pointers alone define validity.
    always_ff @(posedge clk) begin
        if (push_store && !rst) begin
            data_mem[wr_ptr_q]  <= in_data;
            shift_mem[wr_ptr_q] <= in_shift[2:0];
        end
    end

    assign out_data   = out_valid ? data_mem[rd_ptr_q] : 8'd0;
    assign out_shift  = out_valid ? {1'b0, shift_mem[rd_ptr_q]} : 4'd0;
    assign level      = level_q;
    assign drop_pulse = drop_pulse_q;
    assign drop_count = drop_count_q;

endmodule

// File: tb/tb_shift_cmd_queue.sv
// Directed bench for shift_cmd_queue with DEPTH=4; inputs change 1 ns after each rising edge.
module tb_shift_cmd_queue;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [3:0] in_shift;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [3:0] out_shift;
    logic [2:0] level;
    logic       drop_pulse;
    logic [7:0] drop_count;

    int chk_cnt = 0;
    int err_cnt = 0;

    logic [7:0] exp_data  [12];
    logic [3:0] exp_shift [12];
    logic [7:0] fill_data [4];
    logic [3:0] fill_shift[4];

    shift_cmd_queue #(.DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_shift   (in_shift),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_shift  (out_shift),
        .level      (level),
        .drop_pulse (drop_pulse),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic [3:0] s, input logic r);
        in_valid  = v;
        in_data   = d;
        in_shift  = s;
        out_ready = r;
    endtask

    initial begin
        fill_data  = '{8'h01, 8'h02, 8'h03, 8'h04};
        fill_shift = '{4'd0, 4'd1, 4'd2, 4'd7};

        rst = 1'b1;
        drive(1'b0, 8'h00, 4'd0, 1'b0);
        step();
        step();
        rst = 1'b0;
        check_eq("rst_level", level, 0);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_data", out_data, 0);
        check_eq("rst_out_shift", out_shift, 0);
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_drop_count", drop_count, 0);
        check_eq("rst_drop_pulse", drop_pulse, 0);

        // Single pass-through
        drive(1'b1, 8'h5A, 4'd3, 1'b1);
        step();
        drive(1'b0, 8'h00, 4'd0, 1'b1);
        check_eq("pt_out_valid", out_valid, 1);
        check_eq("pt_out_data", out_data, 8'h5A);
        check_eq("pt_out_shift", out_shift, 3);
        check_eq("pt_level", level, 1);
        step();
        check_eq("pt_level_after", level, 0);
        check_eq("pt_out_valid_after", out_valid, 0);
        check_eq("pt_out_data_idle", out_data, 0);

        // Empty pop is ignored
        step();
        check_eq("underflow_level", level, 0);

        // Fill and stall
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, fill_data[i], fill_shift[i], 1'b0);
            step();
        end
        drive(1'b0, 8'h00, 4'd0, 1'b0);
        check_eq("full_level", level, 4);
        check_eq("full_in_ready", in_ready, 0);
        check_eq("full_head_data", out_data, 8'h01);
        drive(1'b1, 8'h05, 4'd0, 1'b0);
        step();
        check_eq("full_fifth_level", level, 4);
        check_eq("stall_head_data", out_data, 8'h01);
        check_eq("stall_head_shift", out_shift, 0);
        // Push offered while full and popping must still be refused
        drive(1'b1, 8'h55, 4'd0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("drain_valid%0d", i), out_valid, 1);
            check_eq($sformatf("drain_data%0d", i), out_data, fill_data[i]);
            check_eq($sformatf("drain_shift%0d", i), out_shift, fill_shift[i]);
            step();
            drive(1'b0, 8'h00, 4'd0, 1'b1);
        end
        check_eq("drain_level", level, 0);
        check_eq("drain_out_valid", out_valid, 0);

        // Reject
        drive(1'b1, 8'hFF, 4'd9, 1'b0);
        step();
        drive(1'b0, 8'h00, 4'd0, 1'b0);
        check_eq("rej_pulse", drop_pulse, 1);
        check_eq("rej_count", drop_count, 1);
        check_eq("rej_level", level, 0);
        check_eq("rej_out_valid", out_valid, 0);
        step();
        check_eq("rej_pulse_clear", drop_pulse, 0);
        check_eq("rej_count_hold", drop_count, 1);

        // Saturation
        drive(1'b1, 8'h00, 4'd15, 1'b0);
        for (int i = 0; i < 300; i++) begin
            step();
        end
        check_eq("sat_count", drop_count, 255);
        check_eq("sat_pulse", drop_pulse, 1);
        check_eq("sat_level", level, 0);
        drive(1'b0, 8'h00, 4'd0, 1'b0);
        step();
        step();
        check_eq("sat_count_hold", drop_count, 255);
        check_eq("sat_pulse_clear", drop_pulse, 0);

        // Wrap and concurrency, starting from write pointer offset 1
        exp_data[0]  = 8'h20;
        exp_shift[0] = 4'd1;
        exp_data[1]  = 8'h21;
        exp_shift[1] = 4'd2;
        for (int i = 0; i < 10; i++) begin
            exp_data[i+2]  = 8'h10 + 8'(i);
            exp_shift[i+2] = 4'(i % 8);
        end
        drive(1'b1, 8'h20, 4'd1, 1'b0);
        step();
        drive(1'b1, 8'h21, 4'd2, 1'b0);
        step();
        check_eq("wrap_level_init", level, 2);
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, exp_data[i+2], exp_shift[i+2], 1'b1);
            check_eq($sformatf("wrap_data%0d", i), out_data, exp_data[i]);
            check_eq($sformatf("wrap_shift%0d", i), out_shift, exp_shift[i]);
            step();
            check_eq($sformatf("wrap_level%0d", i), level, 2);
        end
        drive(1'b0, 8'h00, 4'd0, 1'b1);
        for (int i = 10; i < 12; i++) begin
            check_eq($sformatf("wrap_tail%0d", i), out_data, exp_data[i]);
            step();
        end
        check_eq("wrap_level_end", level, 0);

        // Rejected push alongside a pop
        drive(1'b1, 8'h30, 4'd4, 1'b0);
        step();
        check_eq("rejpop_level_pre", level, 1);
        drive(1'b1, 8'h31, 4'd8, 1'b1);
        step();
        drive(1'b0, 8'h00, 4'd0, 1'b0);
        check_eq("rejpop_level", level, 0);
        check_eq("rejpop_pulse", drop_pulse, 1);
        check_eq("rejpop_count", drop_count, 255);

        // Reset mid-operation
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'h40 + 8'(i), 4'd5, 1'b0);
            step();
        end
        check_eq("midrst_level_pre", level, 3);
        rst = 1'b1;
        drive(1'b1, 8'h77, 4'd2, 1'b1);
        #1;
        check_eq("midrst_out_valid_during", out_valid, 0);
        check_eq("midrst_in_ready_during", in_ready, 1);
        step();
        rst = 1'b0;
        drive(1'b0, 8'h00, 4'd0, 1'b0);
        check_eq("midrst_level", level, 0);
        check_eq("midrst_out_valid", out_valid, 0);
        check_eq("midrst_out_data", out_data, 0);
        check_eq("midrst_drop_count", drop_count, 0);
        check_eq("midrst_in_ready", in_ready, 1);
        step();
        check_eq("midrst_level_later", level, 0);

        $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
        $finish;
    end

endmodule
